erx_mailbox: RTL and testbench

// - RX-path stage directly downstream of the address remap stage; consumes its registered emesh stream.
// - Intercepts writes to the chip-ID mailbox address and pushes them into a local FWFT FIFO for the host.
// - All other packets pass through, delayed one cycle, to the RX AXI master.
// - Exposes the FIFO head, fill count and sticky overflow/drop status to the config register block.

---
 rtl/erx_mailbox.sv | 148 ++++++++++++++
 tb/tb_erx_mailbox.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/erx_mailbox.sv
// rtl/erx_mailbox.sv - RX mailbox stage: diverts chip-ID mailbox writes into a FWFT FIFO, passes the rest through
//
// Purpose:
//    Sits directly after the address remap stage. Writes that target the
//    chip-ID mailbox address are captured into a first-word-fall-through FIFO
//    for the host; every other packet is forwarded one cycle later to the RX
//    AXI master. Fill level and sticky overflow/drop status are exported.
//
// Configuration macro:
//    ERX_MAILBOX_WIDE_EN - entries hold {srcaddr, data} (64 bits) instead of
//                          data only (32 bits). Hit/handshake/status identical.
//
// Ports:
//    clk               in   core clock, all state on posedge
//    reset             in   synchronous, active-high
//    emesh_access_in   in   packet valid from remap stage
//    emesh_packet_in   in   packet from remap stage
//    emesh_access_out  out  pass-through valid (hits removed)
//    emesh_packet_out  out  pass-through packet (free-running register)
//    mailbox_rd        in   pop FIFO head, one word per cycle
//    mailbox_data      out  FIFO head (combinational from array)
//    mailbox_empty     out  FIFO empty
//    mailbox_full      out  FIFO holds DEPTH words
//    mailbox_count     out  occupancy
//    mailbox_ovf       out  sticky: a hit was dropped
//    mailbox_drops     out  dropped-hit counter, saturating
//    mailbox_ovf_clr   in   clears mailbox_ovf and mailbox_drops

module erx_mailbox #(
   parameter int          PW        = 104,
   parameter logic [11:0] ID        = 12'h808,
   parameter logic [19:0] MB_OFFSET = 20'hF0320,
   parameter int          DEPTH     = 16,
   localparam int         AW        = $clog2(DEPTH),
   localparam int         CW        = AW + 1,
`ifdef ERX_MAILBOX_WIDE_EN
   localparam int         MW        = 64
`else
   localparam int         MW        = 32
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          emesh_access_in,
   input  logic [PW-1:0] emesh_packet_in,
   output logic          emesh_access_out,
   output logic [PW-1:0] emesh_packet_out,
   input  logic          mailbox_rd,
   output logic [MW-1:0] mailbox_data,
   output logic          mailbox_empty,
   output logic          mailbox_full,
   output logic [CW-1:0] mailbox_count,
   output logic          mailbox_ovf,
   output logic [7:0]    mailbox_drops,
   input  logic          mailbox_ovf_clr
);

   logic [MW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          ovf_q,    ovf_d;
   logic [7:0]    drops_q,  drops_d;
   logic          access_q;
   logic [PW-1:0] packet_q;

   logic          hit, pop, push, drop;
   logic [MW-1:0] wr_word;

   assign hit = emesh_access_in & emesh_packet_in[0]
              & (emesh_packet_in[39:28] == ID)
              & (emesh_packet_in[27:8]  == MB_OFFSET);

`ifdef ERX_MAILBOX_WIDE_EN
   assign wr_word = {emesh_packet_in[103:72], emesh_packet_in[71:40]};
`else
   assign wr_word = emesh_packet_in[71:40];
`endif

   assign mailbox_empty = (count_q == '0);
   assign mailbox_full  = (count_q == CW'(DEPTH));

   // A pop in the same cycle frees the slot, so a hit on a full FIFO still lands.
   assign pop  = mailbox_rd & ~mailbox_empty;
   assign push = hit & (~mailbox_full | pop);
   assign drop = hit & mailbox_full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      drops_d  = drops_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Clear takes priority over a coincident drop.
      if (mailbox_ovf_clr) begin
         ovf_d   = 1'b0;
         drops_d = 8'h00;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drops_q != 8'hFF) drops_d = drops_q + 8'h01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         drops_q  <= 8'h00;
         access_q <= 1'b0;
         packet_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         drops_q  <= drops_d;
         access_q <= emesh_access_in & ~hit;
         packet_q <= emesh_packet_in;
      end
   end

   // Storage is deliberately not reset; gate writes during reset so an
   // in-flight hit cannot land.
   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr_q] <= wr_word;
   end

   assign mailbox_data     = mem[rd_ptr_q];
   assign mailbox_count    = count_q;
   assign mailbox_ovf      = ovf_q;
   assign mailbox_drops    = drops_q;
   assign emesh_access_out = access_q;
   assign emesh_packet_out = packet_q;

endmodule

// File: tb/tb_erx_mailbox.sv
// tb/tb_erx_mailbox.sv - directed table-driven bench for erx_mailbox

module tb_erx_mailbox;

`ifdef ERX_MAILBOX_WIDE_EN
   localparam int MW = 64;
`else
   localparam int MW = 32;
`endif
   localparam int PW = 104;
   localparam logic [31:0] MBX = 32'h808F0320;
   localparam logic [31:0] SRC = 32'h80C00010;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          emesh_access_in = 1'b0;
   logic [PW-1:0] emesh_packet_in = '0;
   logic          emesh_access_out;
   logic [PW-1:0] emesh_packet_out;
   logic          mailbox_rd = 1'b0;
   logic [MW-1:0] mailbox_data;
   logic          mailbox_empty, mailbox_full, mailbox_ovf;
   logic [4:0]    mailbox_count;
   logic [7:0]    mailbox_drops;
   logic          mailbox_ovf_clr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   erx_mailbox dut (
      .clk              (clk),
      .reset            (reset),
      .emesh_access_in  (emesh_access_in),
      .emesh_packet_in  (emesh_packet_in),
      .emesh_access_out (emesh_access_out),
      .emesh_packet_out (emesh_packet_out),
      .mailbox_rd       (mailbox_rd),
      .mailbox_data     (mailbox_data),
      .mailbox_empty    (mailbox_empty),
      .mailbox_full     (mailbox_full),
      .mailbox_count    (mailbox_count),
      .mailbox_ovf      (mailbox_ovf),
      .mailbox_drops    (mailbox_drops),
      .mailbox_ovf_clr  (mailbox_ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        acc;
      logic        wr;
      logic [31:0] dst;
      logic [31:0] data;
      logic        rd;
      logic        exp_acc;
      logic [4:0]  exp_cnt;
      logic        exp_empty;
      logic        chk_data;
      logic [31:0] exp_data;
   } vec_t;

   function automatic logic [PW-1:0] pkt(input logic wr, input logic [31:0] dst,
                                         input logic [31:0] data, input logic [31:0] src);
      return {src, data, dst, 7'd0, wr};
   endfunction

   function automatic logic [MW-1:0] word(input logic [31:0] data);
`ifdef ERX_MAILBOX_WIDE_EN
      return {SRC, data};
`else
      return data;
`endif
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample #1 after the edge.
   task automatic cyc(input logic acc, input logic wr, input logic [31:0] dst,
                      input logic [31:0] data, input logic rd, input logic clr);
      emesh_access_in = acc;
      emesh_packet_in = pkt(wr, dst, data, SRC);
      mailbox_rd      = rd;
      mailbox_ovf_clr = clr;
      @(posedge clk);
      #1;
      emesh_access_in = 1'b0;
      mailbox_rd      = 1'b0;
      mailbox_ovf_clr = 1'b0;
   endtask

   task automatic fill(input logic [31:0] base);
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, MBX, base + 32'(i), 1'b0, 1'b0);
   endtask

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1, 1, MBX,          32'hDEADBEEF, 0, 0, 5'd1, 0, 1, 32'hDEADBEEF};
      vecs[1] = '{1, 1, 32'h80800000, 32'h11111111, 0, 1, 5'd1, 0, 1, 32'hDEADBEEF};
      vecs[2] = '{1, 0, MBX,          32'h22222222, 0, 1, 5'd1, 0, 1, 32'hDEADBEEF};
      vecs[3] = '{1, 1, 32'h809F0320, 32'h33333333, 0, 1, 5'd1, 0, 0, 32'h0};
      vecs[4] = '{1, 1, 32'h808F0324, 32'h44444444, 0, 1, 5'd1, 0, 0, 32'h0};
      vecs[5] = '{0, 0, 32'h0,        32'h0,        1, 0, 5'd0, 1, 0, 32'h0};
      vecs[6] = '{0, 0, 32'h0,        32'h0,        1, 0, 5'd0, 1, 0, 32'h0};
      vecs[7] = '{1, 1, MBX,          32'h00000001, 1, 0, 5'd1, 0, 1, 32'h00000001};
      vecs[8] = '{1, 1, MBX,          32'h00000002, 1, 0, 5'd1, 0, 1, 32'h00000002};
      vecs[9] = '{0, 0, 32'h0,        32'h0,        1, 0, 5'd0, 1, 0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_access_out", 128'(emesh_access_out), 128'(0));
      chk("rst_packet_out", 128'(emesh_packet_out), 128'(0));
      chk("rst_count",      128'(mailbox_count),    128'(0));
      chk("rst_empty",      128'(mailbox_empty),    128'(1));
      chk("rst_full",       128'(mailbox_full),     128'(0));
      chk("rst_ovf",        128'(mailbox_ovf),      128'(0));
      chk("rst_drops",      128'(mailbox_drops),    128'(0));

      for (int v = 0; v < 10; v++) begin
         cyc(vecs[v].acc, vecs[v].wr, vecs[v].dst, vecs[v].data, vecs[v].rd, 1'b0);
         chk($sformatf("v%0d_access_out", v), 128'(emesh_access_out), 128'(vecs[v].exp_acc));
         chk($sformatf("v%0d_count", v), 128'(mailbox_count), 128'(vecs[v].exp_cnt));
         chk($sformatf("v%0d_empty", v), 128'(mailbox_empty), 128'(vecs[v].exp_empty));
         chk($sformatf("v%0d_packet_out", v), 128'(emesh_packet_out),
             128'(pkt(vecs[v].wr, vecs[v].dst, vecs[v].data, SRC)));
         if (vecs[v].chk_data)
            chk($sformatf("v%0d_data", v), 128'(mailbox_data), 128'(word(vecs[v].exp_data)));
      end

      // Fill, then two drops; pop back in order.
      fill(32'hA0000000);
      cyc(1'b1, 1'b1, MBX, 32'hA00000F0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, MBX, 32'hA00000F1, 1'b0, 1'b0);
      chk("ovfl_access_out", 128'(emesh_access_out), 128'(0));
      chk("ovfl_full",  128'(mailbox_full),  128'(1));
      chk("ovfl_count", 128'(mailbox_count), 128'(16));
      chk("ovfl_ovf",   128'(mailbox_ovf),   128'(1));
      chk("ovfl_drops", 128'(mailbox_drops), 128'(2));
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovfl_pop%0d", i), 128'(mailbox_data), 128'(word(32'hA0000000 + 32'(i))));
         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      chk("ovfl_drained", 128'(mailbox_empty), 128'(1));
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("clr_ovf", 128'(mailbox_ovf), 128'(0));

      // Full: push and pop together.
      fill(32'hB0000000);
      cyc(1'b1, 1'b1, MBX, 32'hBEEF0016, 1'b1, 1'b0);
      chk("pp_count", 128'(mailbox_count), 128'(16));
      chk("pp_ovf",   128'(mailbox_ovf),   128'(0));
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("pp_pop%0d", i), 128'(mailbox_data), 128'(word(32'hB0000000 + 32'(i))));
         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      chk("pp_last", 128'(mailbox_data), 128'(word(32'hBEEF0016)));
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("pp_empty", 128'(mailbox_empty), 128'(1));

      // Read while empty, then clear coinciding with a drop, then saturation.
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("rdempty_count", 128'(mailbox_count), 128'(0));
      fill(32'hC0000000);
      chk("rdempty_ptr_head", 128'(mailbox_data), 128'(word(32'hC0000000)));
      cyc(1'b1, 1'b1, MBX, 32'hC00000FF, 1'b0, 1'b0);
      chk("drop1_drops", 128'(mailbox_drops), 128'(1));
      cyc(1'b1, 1'b1, MBX, 32'hC00000FE, 1'b0, 1'b1);
      chk("clrdrop_ovf",   128'(mailbox_ovf),   128'(0));
      chk("clrdrop_drops", 128'(mailbox_drops), 128'(0));
      chk("clrdrop_count", 128'(mailbox_count), 128'(16));
      chk("clrdrop_head",  128'(mailbox_data),  128'(word(32'hC0000000)));
      for (int i = 0; i < 260; i++) cyc(1'b1, 1'b1, MBX, 32'h0, 1'b0, 1'b0);
      chk("sat_drops", 128'(mailbox_drops), 128'(8'hFF));
      chk("sat_ovf",   128'(mailbox_ovf),   128'(1));

      // Reset mid-stream.
      reset = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, MBX, 32'hD0000000 + 32'(i), 1'b0, 1'b0);
      chk("pre_rst_count", 128'(mailbox_count), 128'(5));
      reset = 1'b1;
      cyc(1'b1, 1'b1, 32'h80800000, 32'h55555555, 1'b0, 1'b0);
      reset = 1'b0;
      chk("midrst_count",      128'(mailbox_count),    128'(0));
      chk("midrst_empty",      128'(mailbox_empty),    128'(1));
      chk("midrst_access_out", 128'(emesh_access_out), 128'(0));
      chk("midrst_packet_out", 128'(emesh_packet_out), 128'(0));
      chk("midrst_drops",      128'(mailbox_drops),    128'(0));
      cyc(1'b1, 1'b1, MBX, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("postrst_count", 128'(mailbox_count), 128'(1));
      chk("postrst_data",  128'(mailbox_data),  128'(word(32'hDEADBEEF)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
